// File: rtl/mem_bus_pkg.sv
// Shared types and sizing helpers for the memory bus controller.
// Holds the FSM state encoding and the strobe counter width rule.
package mem_bus_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    TURN
  } state_e;

  function automatic int cnt_w(
    input int rd,
    input int wr
  );
    int m;
    m = (rd > wr) ? rd : wr;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/bidir_buf.sv
// Tri-state pad driver for a shared data bus.
// Drives pad_io only while oe_i is high; q_o always sees the bus.
module bidir_buf #(
  parameter int DATA_W = 8
) (
  input  logic              oe_i,
  input  logic [DATA_W-1:0] d_i,
  inout  wire  [DATA_W-1:0] pad_io,
  output logic [DATA_W-1:0] q_o
);

  assign pad_io = oe_i ? d_i : {DATA_W{1'bz}};
  assign q_o    = pad_io;

endmodule

// File: rtl/mem_bus_ctrl.sv
// Single-transfer controller for an asynchronous SRAM-style bus.
// Accepts one request in IDLE, strobes, then pulses rsp_valid in TURN.
module mem_bus_ctrl
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_CYC = 2,
  parameter int WR_CYC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] ram_address,
  inout  wire  [DATA_W-1:0] ram_data,
  output logic              ram_read,
  output logic              ram_write
);

  localparam int CW = cnt_w(RD_CYC, WR_CYC);
  localparam logic [CW-1:0] RD_LAST = CW'(RD_CYC - 1);
  localparam logic [CW-1:0] WR_LAST = CW'(WR_CYC - 1);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] bus_in;
  logic              wr_oe;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = '0;
          state_d = req_we ? WRITE : READ;
        end
      end
      WRITE: begin
        if (cnt_q == WR_LAST) begin
          state_d = TURN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      READ: begin
        // Sample on the edge that closes the final strobe cycle.
        if (cnt_q == RD_LAST) begin
          state_d = TURN;
          rdata_d = bus_in;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      TURN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign rsp_valid   = (state_q == TURN);
  assign ram_read    = (state_q == READ);
  assign ram_write   = (state_q == WRITE);
  assign wr_oe       = (state_q == WRITE);
  assign ram_address = addr_q;
  assign rsp_rdata   = rdata_q;

  bidir_buf #(
    .DATA_W(DATA_W)
  ) u_buf (
    .oe_i  (wr_oe),
    .d_i   (wdata_q),
    .pad_io(ram_data),
    .q_o   (bus_in)
  );

endmodule

// File: doc/mem_bus_ctrl.md
MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 10, RAM address width; DATA_W, default 8, RAM data width; RD_CYC, default 2, read-strobe cycles (>=1); WR_CYC, default 1, write-strobe cycles (>=1).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  1  requester presents a transfer.
REQ-005 req_ready  output  1  controller can accept a transfer this cycle.
REQ-006 req_we  input  1  1 = write, 0 = read; sampled at accept.
REQ-007 req_addr  input  ADDR_W  transfer address; sampled at accept.
REQ-008 req_wdata  input  DATA_W  write data; sampled at accept.
REQ-009 rsp_valid  output  1  one-cycle completion pulse, reads and writes.
REQ-010 rsp_rdata  output  DATA_W  read result; holds until the next read completes.
REQ-011 ram_address  output  ADDR_W  RAM address.
REQ-012 ram_data  inout  DATA_W  shared RAM data bus; driven by the controller only during write strobes, else high-Z.
REQ-013 ram_read  output  1  RAM read strobe.
REQ-014 ram_write  output  1  RAM write strobe.

Function
REQ-015 FSM states SHALL be IDLE, WRITE, READ, TURN; reset state IDLE.
REQ-016 req_ready SHALL be 1 only in IDLE; a transfer is accepted on an edge where req_valid&&req_ready.
REQ-017 At accept, addr/we/wdata SHALL be captured; next state WRITE if we=1, else READ.
REQ-018 In WRITE: ram_write=1 and ram_data=captured wdata for exactly WR_CYC cycles, then TURN.
REQ-019 In READ: ram_read=1 for exactly RD_CYC cycles; ram_data sampled into rsp_rdata on the edge ending the last READ cycle; then TURN.
REQ-020 In TURN (always one cycle): strobes 0, bus high-Z, rsp_valid=1; next state IDLE.
REQ-021 ram_address SHALL equal the captured address from the first strobe cycle through TURN, and SHALL hold its last value in IDLE.
REQ-022 ram_read and ram_write SHALL never be 1 in the same cycle; ram_data SHALL never be driven while ram_read=1.
REQ-023 Latency: accept at edge E -> strobe cycles E+1..E+N (N=WR_CYC or RD_CYC) -> rsp_valid in cycle E+N+1 -> req_ready in cycle E+N+2.
REQ-024 req_valid while not in IDLE SHALL be ignored; the requester holds it until req_ready.
REQ-025 rsp_valid has no back-pressure; rsp_rdata SHALL be unchanged by writes.
REQ-026 Strobe-length counter width SHALL be ceil(log2(max(RD_CYC,WR_CYC)+1)) bits, cleared on entry to WRITE/READ.
REQ-027 The full address range 0..2^ADDR_W-1 SHALL be legal; there is no increment and no wrap.

Reset
REQ-028 While rst_n=0, asynchronously: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, ram_address=0, ram_read=0, ram_write=0, ram_data high-Z.
REQ-029 Reset during WRITE/READ/TURN SHALL drop the in-flight transfer with no rsp_valid; the first accept after release behaves per REQ-023.

Structure
REQ-030 Package mem_bus_pkg SHALL hold the state enum, ADDR_W/DATA_W defaults and the strobe-counter width function.
REQ-031 One sub-module, bidir_buf (DATA_W tri-state driver with output enable), SHALL drive ram_data; FSM and counter stay in mem_bus_ctrl.

Verification
REQ-032 Write 0x05 to addr 0x001, then read 0x001 -> ram_write high WR_CYC cycles with bus=0x05; read rsp_valid pulse with rsp_rdata=0x05.
REQ-033 Write 0x0A to 0x002, write 0x05 to 0x001, read 0x002 back to back with req_valid held -> accepts only in IDLE, three rsp_valid pulses, rsp_rdata=0x0A.
REQ-034 Write 0xFF to 0x3FF, read 0x3FF, read 0x000 (preloaded 0x00) -> rsp_rdata 0xFF then 0x00; address stable across each strobe window.
REQ-035 Pull rst_n low mid-READ (RD_CYC=2, second cycle) -> strobes 0 and bus Z in the same cycle, no rsp_valid, rsp_rdata=0, req_ready=1.
REQ-036 Every cycle assert !(ram_read&&ram_write) and no driven ram_data while ram_read=1; with RD_CYC=3/WR_CYC=2 check latencies match REQ-023.
